// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//
// Two-entry issue/retire pipeline wrapped around a combinational ALU.
//   S1: decodes the instruction, selects the operands and registers them as
//       the ALU inputs (ALU_OP1/ALU_OP2/ALU_OPRN), with the writeback sidebands.
//   S2: captures ALU_OUT/ALU_ZERO and the sidebands as the writeback result.
// One bundle per cycle, two-cycle latency, backpressure from OUT_READY.
//
// Ports
//   CLK, RST          clock (rising edge), asynchronous active-low reset
//   IN_VALID/IN_READY upstream handshake for {INSTR, R1_DATA, R2_DATA}
//   ALU_OP1/OP2/OPRN  registered operands and operation code to the ALU
//   ALU_OUT/ALU_ZERO  combinational ALU result and zero flag
//   OUT_VALID/READY   downstream handshake for the result register
//   RESULT, ZERO      registered ALU result and zero flag
//   WADDR, WEN        destination register and write enable
//   ILLEGAL           retired bundle did not decode
// ---------------------------------------------------------------------------
module alu_issue_stage (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] INSTR,
  input  logic [31:0] R1_DATA,
  input  logic [31:0] R2_DATA,
  output logic [31:0] ALU_OP1,
  output logic [31:0] ALU_OP2,
  output logic [5:0]  ALU_OPRN,
  input  logic [31:0] ALU_OUT,
  input  logic        ALU_ZERO,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] RESULT,
  output logic        ZERO,
  output logic [4:0]  WADDR,
  output logic        WEN,
  output logic        ILLEGAL
);

  // Primary opcodes
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SLTI  = 6'h0a;
  localparam logic [5:0] OPC_ANDI  = 6'h0c;
  localparam logic [5:0] OPC_ORI   = 6'h0d;
  localparam logic [5:0] OPC_LUI   = 6'h0f;
  localparam logic [5:0] OPC_MULI  = 6'h1d;

  // R-type funct codes
  localparam logic [5:0] FN_SLL = 6'h01;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2a;
  localparam logic [5:0] FN_MUL = 6'h2c;

  // ALU operation codes
  localparam logic [5:0] OPRN_NONE = 6'h00;
  localparam logic [5:0] OPRN_ADD  = 6'h01;
  localparam logic [5:0] OPRN_SUB  = 6'h02;
  localparam logic [5:0] OPRN_MUL  = 6'h03;
  localparam logic [5:0] OPRN_SRL  = 6'h04;
  localparam logic [5:0] OPRN_SLL  = 6'h05;
  localparam logic [5:0] OPRN_AND  = 6'h06;
  localparam logic [5:0] OPRN_OR   = 6'h07;
  localparam logic [5:0] OPRN_NOR  = 6'h08;
  localparam logic [5:0] OPRN_SLT  = 6'h09;

  // Instruction fields
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic        unused_rs;

  assign opcode   = INSTR[31:26];
  assign funct    = INSTR[5:0];
  assign rt       = INSTR[20:16];
  assign rd       = INSTR[15:11];
  assign shamt    = INSTR[10:6];
  assign imm_sext = {{16{INSTR[15]}}, INSTR[15:0]};
  assign imm_zext = {16'b0, INSTR[15:0]};
  // rs selects the register-file read upstream; its value arrives as R1_DATA.
  assign unused_rs = ^INSTR[25:21];

  // ---- Stage p0: combinational decode / operand select ----
  logic [31:0] op1_p0;
  logic [31:0] op2_p0;
  logic [5:0]  oprn_p0;
  logic [4:0]  waddr_p0;
  logic        wen_p0;
  logic        ill_p0;

  always_comb begin
    op1_p0   = 32'b0;
    op2_p0   = 32'b0;
    oprn_p0  = OPRN_NONE;
    waddr_p0 = 5'b0;
    wen_p0   = 1'b0;
    ill_p0   = 1'b1;
    case (opcode)
      OPC_RTYPE: begin
        case (funct)
          FN_ADD, FN_SUB, FN_MUL, FN_AND, FN_OR, FN_NOR, FN_SLT: begin
            op1_p0   = R1_DATA;
            op2_p0   = R2_DATA;
            waddr_p0 = rd;
            wen_p0   = 1'b1;
            ill_p0   = 1'b0;
            case (funct)
              FN_ADD:  oprn_p0 = OPRN_ADD;
              FN_SUB:  oprn_p0 = OPRN_SUB;
              FN_MUL:  oprn_p0 = OPRN_MUL;
              FN_AND:  oprn_p0 = OPRN_AND;
              FN_OR:   oprn_p0 = OPRN_OR;
              FN_NOR:  oprn_p0 = OPRN_NOR;
              default: oprn_p0 = OPRN_SLT;
            endcase
          end
          FN_SRL, FN_SLL: begin
            op1_p0   = R1_DATA;
            op2_p0   = {27'b0, shamt};
            oprn_p0  = (funct == FN_SRL) ? OPRN_SRL : OPRN_SLL;
            waddr_p0 = rd;
            wen_p0   = 1'b1;
            ill_p0   = 1'b0;
          end
          default: ;
        endcase
      end
      OPC_ADDI, OPC_MULI, OPC_SLTI, OPC_ANDI, OPC_ORI: begin
        op1_p0   = R1_DATA;
        waddr_p0 = rt;
        wen_p0   = 1'b1;
        ill_p0   = 1'b0;
        case (opcode)
          OPC_ADDI: begin oprn_p0 = OPRN_ADD; op2_p0 = imm_sext; end
          OPC_MULI: begin oprn_p0 = OPRN_MUL; op2_p0 = imm_sext; end
          OPC_SLTI: begin oprn_p0 = OPRN_SLT; op2_p0 = imm_sext; end
          OPC_ANDI: begin oprn_p0 = OPRN_AND; op2_p0 = imm_zext; end
          default:  begin oprn_p0 = OPRN_OR;  op2_p0 = imm_zext; end
        endcase
      end
      OPC_LUI: begin
        // lui is executed as a 16-bit left shift of the zero-extended immediate.
        op1_p0   = imm_zext;
        op2_p0   = 32'd16;
        oprn_p0  = OPRN_SLL;
        waddr_p0 = rt;
        wen_p0   = 1'b1;
        ill_p0   = 1'b0;
      end
      default: ;
    endcase
  end

  // ---- Handshake control ----
  logic [31:0] op1_p1;
  logic [31:0] op2_p1;
  logic [5:0]  oprn_p1;
  logic [4:0]  waddr_p1;
  logic        wen_p1;
  logic        ill_p1;
  logic        vld_p1;

  logic [31:0] result_p2;
  logic        zero_p2;
  logic [4:0]  waddr_p2;
  logic        wen_p2;
  logic        ill_p2;
  logic        vld_p2;

  logic s2_take;
  logic in_fire;

  assign s2_take  = vld_p1 && (!vld_p2 || OUT_READY);
  assign IN_READY = !vld_p1 || s2_take;
  assign in_fire  = IN_VALID && IN_READY;

  // ---- Stage p1: registered ALU operands and sidebands ----
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      vld_p1   <= 1'b0;
      op1_p1   <= 32'b0;
      op2_p1   <= 32'b0;
      oprn_p1  <= 6'b0;
      waddr_p1 <= 5'b0;
      wen_p1   <= 1'b0;
      ill_p1   <= 1'b0;
    end else if (in_fire) begin
      vld_p1   <= 1'b1;
      op1_p1   <= op1_p0;
      op2_p1   <= op2_p0;
      oprn_p1  <= oprn_p0;
      waddr_p1 <= waddr_p0;
      wen_p1   <= wen_p0;
      ill_p1   <= ill_p0;
    end else if (s2_take) begin
      vld_p1 <= 1'b0;
    end
  end

  // ---- Stage p2: registered ALU result for writeback ----
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      vld_p2    <= 1'b0;
      result_p2 <= 32'b0;
      zero_p2   <= 1'b0;
      waddr_p2  <= 5'b0;
      wen_p2    <= 1'b0;
      ill_p2    <= 1'b0;
    end else if (s2_take) begin
      vld_p2    <= 1'b1;
      result_p2 <= ALU_OUT;
      zero_p2   <= ALU_ZERO;
      waddr_p2  <= waddr_p1;
      wen_p2    <= wen_p1;
      ill_p2    <= ill_p1;
    end else if (vld_p2 && OUT_READY) begin
      vld_p2 <= 1'b0;
    end
  end

  assign ALU_OP1   = op1_p1;
  assign ALU_OP2   = op2_p1;
  assign ALU_OPRN  = oprn_p1;
  assign OUT_VALID = vld_p2;
  assign RESULT    = result_p2;
  assign ZERO      = zero_p2;
  assign WADDR     = waddr_p2;
  assign WEN       = wen_p2;
  assign ILLEGAL   = ill_p2;

endmodule

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage
//
// Drives alu_issue_stage with a behavioural ALU on its ALU_* ports, applies a
// table of single-instruction vectors and a few multi-cycle sequences
// (streaming, backpressure, reset with both stages full).
// ---------------------------------------------------------------------------
module tb_alu_issue_stage;

  logic        CLK;
  logic        RST;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] INSTR;
  logic [31:0] R1_DATA;
  logic [31:0] R2_DATA;
  logic [31:0] ALU_OP1;
  logic [31:0] ALU_OP2;
  logic [5:0]  ALU_OPRN;
  logic [31:0] ALU_OUT;
  logic        ALU_ZERO;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] RESULT;
  logic        ZERO;
  logic [4:0]  WADDR;
  logic        WEN;
  logic        ILLEGAL;

  int n_tests;
  int n_fail;

  alu_issue_stage dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .INSTR(INSTR), .R1_DATA(R1_DATA), .R2_DATA(R2_DATA),
    .ALU_OP1(ALU_OP1), .ALU_OP2(ALU_OP2), .ALU_OPRN(ALU_OPRN),
    .ALU_OUT(ALU_OUT), .ALU_ZERO(ALU_ZERO),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .RESULT(RESULT), .ZERO(ZERO), .WADDR(WADDR), .WEN(WEN), .ILLEGAL(ILLEGAL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural ALU
  always_comb begin
    case (ALU_OPRN)
      6'h01:   ALU_OUT = ALU_OP1 + ALU_OP2;
      6'h02:   ALU_OUT = ALU_OP1 - ALU_OP2;
      6'h03:   ALU_OUT = ALU_OP1 * ALU_OP2;
      6'h04:   ALU_OUT = ALU_OP1 >> ALU_OP2;
      6'h05:   ALU_OUT = ALU_OP1 << ALU_OP2;
      6'h06:   ALU_OUT = ALU_OP1 & ALU_OP2;
      6'h07:   ALU_OUT = ALU_OP1 | ALU_OP2;
      6'h08:   ALU_OUT = ~(ALU_OP1 | ALU_OP2);
      6'h09:   ALU_OUT = ($signed(ALU_OP1) < $signed(ALU_OP2)) ? 32'd1 : 32'd0;
      default: ALU_OUT = 32'd0;
    endcase
    ALU_ZERO = (ALU_OUT == 32'd0);
  end

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] op2;
    logic [5:0]  oprn;
    logic [31:0] res;
    logic        zero;
    logic [4:0]  waddr;
    logic        wen;
    logic        ill;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [0:NVEC-1];

  vec_t bb [0:2];
  logic [31:0] bp_exp [0:2];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;

    //            instr                                  r1            r2            op2           oprn   res           z     wa     wen   ill
    vecs[0]  = '{rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20),  32'd5,        32'd7,        32'd7,        6'h01, 32'd12,       1'b0, 5'd3,  1'b1, 1'b0};
    vecs[1]  = '{rtype(5'd1, 5'd2, 5'd4, 5'd0, 6'h22),  32'd3,        32'd3,        32'd3,        6'h02, 32'd0,        1'b1, 5'd4,  1'b1, 1'b0};
    vecs[2]  = '{itype(6'h0a, 5'd1, 5'd5, 16'h0000),    32'hFFFFFFFF, 32'd0,        32'd0,        6'h09, 32'd1,        1'b0, 5'd5,  1'b1, 1'b0};
    vecs[3]  = '{itype(6'h0f, 5'd0, 5'd6, 16'h1234),    32'hDEADBEEF, 32'd0,        32'd16,       6'h05, 32'h12340000, 1'b0, 5'd6,  1'b1, 1'b0};
    vecs[4]  = '{rtype(5'd1, 5'd0, 5'd7, 5'd31, 6'h01), 32'd1,        32'd99,       32'd31,       6'h05, 32'h80000000, 1'b0, 5'd7,  1'b1, 1'b0};
    vecs[5]  = '{itype(6'h0c, 5'd1, 5'd8, 16'h8000),    32'hFFFFFFFF, 32'd0,        32'h00008000, 6'h06, 32'h00008000, 1'b0, 5'd8,  1'b1, 1'b0};
    vecs[6]  = '{itype(6'h08, 5'd1, 5'd9, 16'hFFFF),    32'd10,       32'd0,        32'hFFFFFFFF, 6'h01, 32'd9,        1'b0, 5'd9,  1'b1, 1'b0};
    vecs[7]  = '{rtype(5'd1, 5'd0, 5'd10, 5'd4, 6'h02), 32'h80000000, 32'd0,        32'd4,        6'h04, 32'h08000000, 1'b0, 5'd10, 1'b1, 1'b0};
    vecs[8]  = '{rtype(5'd1, 5'd2, 5'd11, 5'd0, 6'h27), 32'd0,        32'd0,        32'd0,        6'h08, 32'hFFFFFFFF, 1'b0, 5'd11, 1'b1, 1'b0};
    vecs[9]  = '{rtype(5'd1, 5'd2, 5'd12, 5'd0, 6'h2c), 32'd6,        32'd7,        32'd7,        6'h03, 32'd42,       1'b0, 5'd12, 1'b1, 1'b0};
    vecs[10] = '{itype(6'h0d, 5'd1, 5'd13, 16'h8001),   32'hF0000000, 32'd0,        32'h00008001, 6'h07, 32'hF0008001, 1'b0, 5'd13, 1'b1, 1'b0};
    vecs[11] = '{itype(6'h3f, 5'd1, 5'd14, 16'h1234),   32'd77,       32'd88,       32'd0,        6'h00, 32'd0,        1'b1, 5'd0,  1'b0, 1'b1};
    vecs[12] = '{rtype(5'd1, 5'd2, 5'd15, 5'd0, 6'h2a), 32'hFFFFFFFB, 32'd3,        32'd3,        6'h09, 32'd1,        1'b0, 5'd15, 1'b1, 1'b0};
    vecs[13] = '{rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'h20),  32'd1,        32'd2,        32'd2,        6'h01, 32'd3,        1'b0, 5'd0,  1'b1, 1'b0};
    vecs[14] = '{rtype(5'd1, 5'd2, 5'd16, 5'd0, 6'h3f), 32'd4,        32'd5,        32'd0,        6'h00, 32'd0,        1'b1, 5'd0,  1'b0, 1'b1};

    IN_VALID  = 1'b0;
    INSTR     = 32'd0;
    R1_DATA   = 32'd0;
    R2_DATA   = 32'd0;
    OUT_READY = 1'b1;
    RST       = 1'b0;

    // Reset state
    repeat (2) @(negedge CLK);
    check("rst_in_ready",  {31'b0, IN_READY},  32'd1);
    check("rst_out_valid", {31'b0, OUT_VALID}, 32'd0);
    check("rst_result",    RESULT,             32'd0);
    check("rst_oprn",      {26'b0, ALU_OPRN},  32'd0);
    check("rst_wen",       {31'b0, WEN},       32'd0);
    RST = 1'b1;
    @(negedge CLK);

    // Table vectors, one at a time
    for (int i = 0; i < NVEC; i++) begin
      IN_VALID = 1'b1;
      INSTR    = vecs[i].instr;
      R1_DATA  = vecs[i].r1;
      R2_DATA  = vecs[i].r2;
      #1;
      check($sformatf("v%0d_in_ready", i), {31'b0, IN_READY}, 32'd1);
      @(negedge CLK);
      IN_VALID = 1'b0;
      check($sformatf("v%0d_oprn", i), {26'b0, ALU_OPRN}, {26'b0, vecs[i].oprn});
      check($sformatf("v%0d_op2", i),  ALU_OP2,           vecs[i].op2);
      @(negedge CLK);
      check($sformatf("v%0d_out_valid", i), {31'b0, OUT_VALID}, 32'd1);
      check($sformatf("v%0d_result", i),    RESULT,             vecs[i].res);
      check($sformatf("v%0d_zero", i),      {31'b0, ZERO},      {31'b0, vecs[i].zero});
      check($sformatf("v%0d_waddr", i),     {27'b0, WADDR},     {27'b0, vecs[i].waddr});
      check($sformatf("v%0d_wen", i),       {31'b0, WEN},       {31'b0, vecs[i].wen});
      check($sformatf("v%0d_illegal", i),   {31'b0, ILLEGAL},   {31'b0, vecs[i].ill});
      @(negedge CLK);
      check($sformatf("v%0d_drained", i), {31'b0, OUT_VALID}, 32'd0);
    end

    // Back-to-back: sub, slti, lui on consecutive cycles
    bb[0] = vecs[1];
    bb[1] = vecs[2];
    bb[2] = vecs[3];
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      if (c >= 2) begin
        check($sformatf("bb%0d_valid", c - 2),  {31'b0, OUT_VALID}, 32'd1);
        check($sformatf("bb%0d_result", c - 2), RESULT,             bb[c-2].res);
        check($sformatf("bb%0d_zero", c - 2),   {31'b0, ZERO},      {31'b0, bb[c-2].zero});
      end
      if (c < 3) begin
        IN_VALID = 1'b1;
        INSTR    = bb[c].instr;
        R1_DATA  = bb[c].r1;
        R2_DATA  = bb[c].r2;
        #1;
        check($sformatf("bb%0d_in_ready", c), {31'b0, IN_READY}, 32'd1);
      end else begin
        IN_VALID = 1'b0;
      end
    end
    @(negedge CLK);
    check("bb_drained", {31'b0, OUT_VALID}, 32'd0);

    // Backpressure: OUT_READY low for 4 cycles while 3 adds are offered
    begin
      int acc;
      int rcv;
      int c;
      logic exp_rdy [0:4];
      exp_rdy[0] = 1'b1; exp_rdy[1] = 1'b1; exp_rdy[2] = 1'b0;
      exp_rdy[3] = 1'b0; exp_rdy[4] = 1'b1;
      bp_exp[0] = 32'd101; bp_exp[1] = 32'd102; bp_exp[2] = 32'd103;
      acc = 0;
      rcv = 0;
      c   = 0;
      while ((rcv < 3) && (c < 20)) begin
        @(negedge CLK);
        OUT_READY = (c >= 4);
        IN_VALID  = (acc < 3);
        INSTR     = rtype(5'd1, 5'd2, 5'd20, 5'd0, 6'h20);
        R1_DATA   = 32'd100;
        R2_DATA   = acc + 1;
        #1;
        if (c < 5)
          check($sformatf("bp_in_ready_c%0d", c), {31'b0, IN_READY}, {31'b0, exp_rdy[c]});
        if ((c == 2) || (c == 3))
          check($sformatf("bp_hold_c%0d", c), RESULT, 32'd101);
        if (OUT_VALID && OUT_READY) begin
          if (rcv < 3) check($sformatf("bp_order%0d", rcv), RESULT, bp_exp[rcv]);
          rcv++;
        end
        if (IN_VALID && IN_READY) acc++;
        c++;
      end
      IN_VALID = 1'b0;
      check("bp_accepted", acc, 32'd3);
      check("bp_received", rcv, 32'd3);
      @(negedge CLK);
      check("bp_drained", {31'b0, OUT_VALID}, 32'd0);
    end

    // Reset with both stages full
    OUT_READY = 1'b0;
    IN_VALID  = 1'b1;
    INSTR     = rtype(5'd1, 5'd2, 5'd21, 5'd0, 6'h20);
    R1_DATA   = 32'd40;
    R2_DATA   = 32'd2;
    @(negedge CLK);
    R1_DATA = 32'd50;
    @(negedge CLK);
    IN_VALID = 1'b0;
    check("full_out_valid", {31'b0, OUT_VALID}, 32'd1);
    check("full_in_ready",  {31'b0, IN_READY},  32'd0);
    #2;
    RST = 1'b0;
    #1;
    check("arst_out_valid", {31'b0, OUT_VALID}, 32'd0);
    check("arst_result",    RESULT,             32'd0);
    check("arst_op1",       ALU_OP1,            32'd0);
    check("arst_oprn",      {26'b0, ALU_OPRN},  32'd0);
    check("arst_waddr",     {27'b0, WADDR},     32'd0);
    check("arst_wen",       {31'b0, WEN},       32'd0);
    check("arst_in_ready",  {31'b0, IN_READY},  32'd1);
    @(negedge CLK);
    RST       = 1'b1;
    OUT_READY = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check($sformatf("post_rst_idle%0d", k), {31'b0, OUT_VALID}, 32'd0);
      check($sformatf("post_rst_rdy%0d", k),  {31'b0, IN_READY},  32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
